// File: rtl/cu_pkg.sv
// Shared state encoding, IR field layout and control-word type for control_unit.
package cu_pkg;

  typedef enum logic [4:0] {
    StF0, StF1, StF2, StF3, StDec,
    StA1, StA2, StA3, StA4, StExec,
    StL0, StL1, StL2, StL3,
    StS0, StS1, StS2,
    StHalt
  } cu_state_e;

  localparam logic [2:0] OP_MOV   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_IN    = 3'b011;
  localparam logic [2:0] OP_OUT   = 3'b100;
  localparam logic [2:0] OP_INP1  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam int unsigned IR_CLASS   = 15;
  localparam int unsigned IR_OP_LSB  = 12;
  localparam int unsigned IR_RD_LSB  = 10;
  localparam int unsigned IR_RS1_LSB = 8;
  localparam int unsigned IR_RS2_LSB = 6;
  localparam int unsigned IR_IMM     = 5;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic       sys;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       imm;
  } ir_fields_t;

  typedef struct packed {
    logic [3:0] g_in;
    logic [3:0] g_out;
    logic       alu_in1;
    logic       alu_in2;
    logic       alu_outlach;
    logic       alu_out_en;
    logic       pc_out;
    logic       pc_inc;
    logic       p0_in;
    logic       p0_out;
    logic       p1_out;
    logic       mar_en;
    logic       mdr_en_write;
    logic       mdr_en_read;
    logic       mdr_out;
    logic       mem_en;
    logic       mem_rw;
    logic       ir_en;
    logic       immediate_out;
    logic       halted;
  } ctrl_t;

  // Only the upper IR bits carry fields the sequencer needs.
  function automatic ir_fields_t split_ir(input logic [15:5] ir_hi);
    ir_fields_t f;
    f.sys = ir_hi[IR_CLASS];
    f.op  = ir_hi[IR_OP_LSB +: 3];
    f.rd  = ir_hi[IR_RD_LSB +: 2];
    f.rs1 = ir_hi[IR_RS1_LSB +: 2];
    f.rs2 = ir_hi[IR_RS2_LSB +: 2];
    f.imm = ir_hi[IR_IMM];
    return f;
  endfunction

  function automatic logic [3:0] reg_sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mfc_waiter.sv
// Counts cycles spent waiting for mfc in a memory state and flags completion or timeout.
module mfc_waiter #(
  parameter int unsigned MFC_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mfc,
  output logic done,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside wait states so every wait starts from a cleared count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!active) begin
      cnt_q <= '0;
    end else if (!mfc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done    = active && mfc;
  assign timeout = active && !mfc && (cnt_q == CNT_W'(MFC_TIMEOUT));

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer; every control output is a registered decode of
// the state being entered, so none depends combinationally on mfc.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MFC_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        mfc,
  output logic [3:0]  g_in,
  output logic [3:0]  g_out,
  output logic        alu_in1,
  output logic        alu_in2,
  output logic        alu_outlach,
  output logic        alu_out_en,
  output logic        pc_out,
  output logic        pc_inc,
  output logic        p0_in,
  output logic        p0_out,
  output logic        p1_out,
  output logic        mar_en,
  output logic        mdr_en_write,
  output logic        mdr_en_read,
  output logic        mdr_out,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        ir_en,
  output logic        immediate_out,
  output logic        halted,
  output logic        fault
);

  cu_state_e  state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  ir_fields_t fld_q, fld;
  logic       armed_q;
  logic       fault_q;
  logic       wait_active;
  logic       mfc_done;
  logic       mfc_timeout;
  logic       unused_ir_lo;

  assign unused_ir_lo = ^ir[4:0];

  assign wait_active = (state_q == StF1) || (state_q == StL1) || (state_q == StS2);

  mfc_waiter #(
    .MFC_TIMEOUT(MFC_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_waiter (
    .clk    (clk),
    .rst    (rst),
    .active (wait_active),
    .mfc    (mfc),
    .done   (mfc_done),
    .timeout(mfc_timeout)
  );

  // IR is read live only in DEC; execute states decode from the copy latched there.
  assign fld = (state_q == StDec) ? split_ir(ir[15:5]) : fld_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // armed_q gives F0 one visible cycle after reset, since outputs clear on reset.
      StF0: if (armed_q) state_d = StF1;
      StF1: begin
        if (mfc_timeout)   state_d = StHalt;
        else if (mfc_done) state_d = StF2;
      end
      StF2:  state_d = StF3;
      StF3:  state_d = StDec;
      StDec: begin
        if (!fld.sys) begin
          state_d = StA1;
        end else begin
          case (fld.op)
            OP_LOAD:  state_d = StL0;
            OP_STORE: state_d = StS0;
            OP_HALT:  state_d = StHalt;
            default:  state_d = StExec;
          endcase
        end
      end
      StA1:   state_d = StA2;
      StA2:   state_d = StA3;
      StA3:   state_d = StA4;
      StA4:   state_d = StF0;
      StExec: state_d = StF0;
      StL0:   state_d = StL1;
      StL1: begin
        if (mfc_timeout)   state_d = StHalt;
        else if (mfc_done) state_d = StL2;
      end
      StL2: state_d = StL3;
      StL3: state_d = StF0;
      StS0: state_d = StS1;
      StS1: state_d = StS2;
      StS2: begin
        if (mfc_timeout)   state_d = StHalt;
        else if (mfc_done) state_d = StF0;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StF0;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      StF0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_en = 1'b1;
      end
      StF1: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.mem_rw = MEM_READ;
      end
      StF2: ctrl_d.mdr_en_read = 1'b1;
      StF3: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_en   = 1'b1;
        ctrl_d.pc_inc  = 1'b1;
      end
      StA1: begin
        ctrl_d.g_out   = reg_sel(fld.rs1);
        ctrl_d.alu_in1 = 1'b1;
      end
      StA2: begin
        if (fld.imm) ctrl_d.immediate_out = 1'b1;
        else         ctrl_d.g_out         = reg_sel(fld.rs2);
        ctrl_d.alu_in2 = 1'b1;
      end
      StA3: ctrl_d.alu_outlach = 1'b1;
      StA4: begin
        ctrl_d.alu_out_en = 1'b1;
        ctrl_d.g_in       = reg_sel(fld.rd);
      end
      StExec: begin
        case (fld.op)
          OP_MOV: begin
            ctrl_d.g_out = reg_sel(fld.rs1);
            ctrl_d.g_in  = reg_sel(fld.rd);
          end
          OP_IN: begin
            ctrl_d.p0_out = 1'b1;
            ctrl_d.g_in   = reg_sel(fld.rd);
          end
          OP_OUT: begin
            ctrl_d.g_out = reg_sel(fld.rd);
            ctrl_d.p0_in = 1'b1;
          end
          OP_INP1: begin
            ctrl_d.p1_out = 1'b1;
            ctrl_d.g_in   = reg_sel(fld.rd);
          end
          default: ;
        endcase
      end
      StL0, StS0: begin
        ctrl_d.g_out  = reg_sel(fld.rs1);
        ctrl_d.mar_en = 1'b1;
      end
      StL1: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.mem_rw = MEM_READ;
      end
      StL2: ctrl_d.mdr_en_read = 1'b1;
      StL3: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.g_in    = reg_sel(fld.rd);
      end
      StS1: begin
        ctrl_d.g_out        = reg_sel(fld.rd);
        ctrl_d.mdr_en_write = 1'b1;
      end
      StS2: begin
        ctrl_d.mem_en = 1'b1;
        ctrl_d.mem_rw = MEM_WRITE;
      end
      StHalt:  ctrl_d.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StF0;
      ctrl_q  <= '0;
      fld_q   <= '0;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      fld_q   <= fld;
      armed_q <= 1'b1;
      if (mfc_timeout) fault_q <= 1'b1;
    end
  end

  assign g_in          = ctrl_q.g_in;
  assign g_out         = ctrl_q.g_out;
  assign alu_in1       = ctrl_q.alu_in1;
  assign alu_in2       = ctrl_q.alu_in2;
  assign alu_outlach   = ctrl_q.alu_outlach;
  assign alu_out_en    = ctrl_q.alu_out_en;
  assign pc_out        = ctrl_q.pc_out;
  assign pc_inc        = ctrl_q.pc_inc;
  assign p0_in         = ctrl_q.p0_in;
  assign p0_out        = ctrl_q.p0_out;
  assign p1_out        = ctrl_q.p1_out;
  assign mar_en        = ctrl_q.mar_en;
  assign mdr_en_write  = ctrl_q.mdr_en_write;
  assign mdr_en_read   = ctrl_q.mdr_en_read;
  assign mdr_out       = ctrl_q.mdr_out;
  assign mem_en        = ctrl_q.mem_en;
  assign mem_rw        = ctrl_q.mem_rw;
  assign ir_en         = ctrl_q.ir_en;
  assign immediate_out = ctrl_q.immediate_out;
  assign halted        = ctrl_q.halted;
  assign fault         = fault_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model queues the expected control word
// for each cycle and a negedge process compares it, plus literal spot checks.
module tb_control_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir  = 16'h0000;
  logic        mfc = 1'b0;
  logic [3:0]  g_in, g_out;
  logic alu_in1, alu_in2, alu_outlach, alu_out_en, pc_out, pc_inc, p0_in, p0_out, p1_out;
  logic mar_en, mdr_en_write, mdr_en_read, mdr_out, mem_en, mem_rw, ir_en, immediate_out;
  logic halted, fault;

  control_unit #(
    .MFC_TIMEOUT(TIMEOUT),
    .CNT_W      (4)
  ) dut (
    .clk(clk), .rst(rst), .ir(ir), .mfc(mfc),
    .g_in(g_in), .g_out(g_out),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_outlach(alu_outlach), .alu_out_en(alu_out_en),
    .pc_out(pc_out), .pc_inc(pc_inc),
    .p0_in(p0_in), .p0_out(p0_out), .p1_out(p1_out),
    .mar_en(mar_en), .mdr_en_write(mdr_en_write), .mdr_en_read(mdr_en_read), .mdr_out(mdr_out),
    .mem_en(mem_en), .mem_rw(mem_rw), .ir_en(ir_en), .immediate_out(immediate_out),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g_in;
    logic [3:0] g_out;
    logic alu_in1, alu_in2, alu_outlach, alu_out_en, pc_out, pc_inc, p0_in, p0_out, p1_out;
    logic mar_en, mdr_en_write, mdr_en_read, mdr_out, mem_en, mem_rw, ir_en, immediate_out;
    logic halted, fault;
  } word_t;

  word_t act;
  assign act = {g_in, g_out, alu_in1, alu_in2, alu_outlach, alu_out_en, pc_out, pc_inc, p0_in,
                p0_out, p1_out, mar_en, mdr_en_write, mdr_en_read, mdr_out, mem_en, mem_rw,
                ir_en, immediate_out, halted, fault};

  word_t exp_q[$];
  word_t hist[$];
  int    total = 0;
  int    bad   = 0;
  logic  noise   = 1'b0;
  logic  m_fault = 1'b0;

  always @(negedge clk) begin
    word_t e;
    hist.push_back(act);
    total++;
    if ($countones({g_out, alu_out_en, pc_out, p0_out, p1_out, mdr_out, immediate_out}) > 1) begin
      bad++;
      $display("FAIL bus_exclusive t=%0t got=%h required at most one driver", $time, act);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL ctrl_word t=%0t got=%h want=%h", $time, act, e);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // One cycle: e is what the outputs must show now; m is mfc for the coming edge.
  task automatic step(input logic m, input word_t e);
    @(posedge clk);
    #1;
    mfc     = m;
    e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Memory wait: mfc stays low for 'delay' cycles; TIMEOUT low cycles counted plus one more faults.
  task automatic mem_wait(input word_t e, input int delay, output logic timed_out);
    timed_out = 1'b0;
    for (int i = 0; i <= TIMEOUT; i++) begin
      step(i >= delay, e);
      if (i >= delay) return;
    end
    timed_out = 1'b1;
    m_fault   = 1'b1;
  endtask

  task automatic halt_cycles(input int n);
    word_t e;
    e        = '0;
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) step(i[0], e);
  endtask

  task automatic fetch(input int f1_delay, input logic [15:0] instr, output logic timed_out);
    word_t e;
    e = '0; e.pc_out = 1'b1; e.mar_en = 1'b1; step(noise, e);
    e = '0; e.mem_en = 1'b1; mem_wait(e, f1_delay, timed_out);
    if (timed_out) return;
    e = '0; e.mdr_en_read = 1'b1; step(noise, e);
    e = '0; e.mdr_out = 1'b1; e.ir_en = 1'b1; e.pc_inc = 1'b1; step(noise, e);
    step(noise, '0);
    ir = instr;
  endtask

  task automatic run(input logic [15:0] instr, input int f1_delay, input int mem_delay);
    word_t e;
    logic to;
    logic [1:0] rd, rs1, rs2;
    fetch(f1_delay, instr, to);
    if (to) return;
    rd  = instr[11:10];
    rs1 = instr[9:8];
    rs2 = instr[7:6];
    if (!instr[15]) begin
      e = '0; e.g_out = onehot(rs1); e.alu_in1 = 1'b1; step(noise, e);
      e = '0;
      if (instr[5]) e.immediate_out = 1'b1;
      else          e.g_out = onehot(rs2);
      e.alu_in2 = 1'b1; step(noise, e);
      e = '0; e.alu_outlach = 1'b1; step(noise, e);
      e = '0; e.alu_out_en = 1'b1; e.g_in = onehot(rd); step(noise, e);
    end else begin
      case (instr[14:12])
        3'd0: begin e = '0; e.g_out = onehot(rs1); e.g_in = onehot(rd); step(noise, e); end
        3'd1: begin
          e = '0; e.g_out = onehot(rs1); e.mar_en = 1'b1; step(noise, e);
          e = '0; e.mem_en = 1'b1; mem_wait(e, mem_delay, to);
          if (to) return;
          e = '0; e.mdr_en_read = 1'b1; step(noise, e);
          e = '0; e.mdr_out = 1'b1; e.g_in = onehot(rd); step(noise, e);
        end
        3'd2: begin
          e = '0; e.g_out = onehot(rs1); e.mar_en = 1'b1; step(noise, e);
          e = '0; e.g_out = onehot(rd); e.mdr_en_write = 1'b1; step(noise, e);
          e = '0; e.mem_en = 1'b1; e.mem_rw = 1'b1; mem_wait(e, mem_delay, to);
        end
        3'd3: begin e = '0; e.p0_out = 1'b1; e.g_in = onehot(rd); step(noise, e); end
        3'd4: begin e = '0; e.g_out = onehot(rd); e.p0_in = 1'b1; step(noise, e); end
        3'd5: begin e = '0; e.p1_out = 1'b1; e.g_in = onehot(rd); step(noise, e); end
        3'd6: step(noise, '0);
        default: halt_cycles(4);
      endcase
    end
  endtask

  task automatic reset_pulse();
    settle();
    rst     = 1'b0;
    m_fault = 1'b0;
    #1;
    lit("reset_outputs_zero", act, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    hist.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t required the bench to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t e;
    logic  to;
    int    n;

    #2;
    lit("reset_state", act, 32'h0);
    #1 rst = 1'b1;

    // Fetch timing and ALU with immediate operand.
    run(16'h0C20, 0, 0);
    settle();
    lit("fetch_c1_pc_mar", {30'd0, hist[0].pc_out, hist[0].mar_en}, 32'h3);
    lit("fetch_c4_ir_pcinc", {29'd0, hist[3].ir_en, hist[3].pc_inc, hist[3].mdr_out}, 32'h7);
    lit("fetch_c5_dec_idle", hist[4], 32'h0);
    n = 0;
    foreach (hist[i]) n += int'(hist[i].pc_inc);
    lit("pc_inc_once", n, 1);
    lit("alu_a1_gout", hist[5].g_out, 32'h1);
    lit("alu_a2_imm", {31'd0, hist[6].immediate_out}, 32'h1);
    lit("alu_a4_gin_outen", {27'd0, hist[8].g_in, hist[8].alu_out_en}, 32'h11);

    // Register-operand ALU, then single-cycle ops with mfc noise outside wait states.
    run(16'h19C0, 2, 0);
    noise = 1'b1;
    run(16'h8B00, 0, 0);
    run(16'hBC00, 1, 0);
    run(16'hC400, 0, 0);
    run(16'hD000, 0, 0);
    noise = 1'b0;

    // LOAD with three low mfc cycles in L1.
    settle();
    hist.delete();
    run(16'h9600, 0, 3);
    settle();
    n = 0;
    for (int i = 6; i <= 9; i++) n += int'(hist[i].mem_en & ~hist[i].mem_rw);
    lit("load_l1_held_4", n, 4);
    lit("load_l2_mdr_read", {31'd0, hist[10].mdr_en_read}, 32'h1);
    lit("load_l3_mdrout_gin", {27'd0, hist[11].mdr_out, hist[11].g_in}, 32'h12);

    // STORE.
    hist.delete();
    run(16'hA100, 0, 0);
    settle();
    lit("store_s0", {27'd0, hist[5].g_out, hist[5].mar_en}, 32'h5);
    lit("store_s1", {27'd0, hist[6].g_out, hist[6].mdr_en_write}, 32'h3);
    lit("store_s2", {30'd0, hist[7].mem_en, hist[7].mem_rw}, 32'h3);

    // mfc arriving on the cycle the counter hits the limit is a success; NOP follows.
    run(16'hE000, TIMEOUT, 0);

    // Async reset in A3.
    fetch(0, 16'h2D40, to);
    e = '0; e.g_out = 4'b0010; e.alu_in1 = 1'b1; step(1'b0, e);
    e = '0; e.g_out = 4'b0010; e.alu_in2 = 1'b1; step(1'b0, e);
    e = '0; e.alu_outlach = 1'b1; step(1'b0, e);
    reset_pulse();

    // HALT, with mfc pulses that must be ignored.
    run(16'h8B00, 0, 0);
    run(16'hF000, 0, 0);
    settle();
    lit("halt_holds", {30'd0, halted, fault}, 32'h2);
    reset_pulse();

    // Fetch timeout.
    run(16'h8000, 100, 0);
    halt_cycles(4);
    settle();
    lit("timeout_last_f1", {31'd0, hist[16].mem_en}, 32'h1);
    lit("timeout_word", hist[17], 32'h3);
    lit("timeout_sticky", hist[hist.size()-1], 32'h3);
    reset_pulse();
    run(16'h0C20, 0, 0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
